lane_occupancy_counter: RTL and testbench

Per-lane vehicle occupancy tracker that sits directly upstream of the traffic-light FSM. It synchronises and conditions raw arrival/departure loop-detector signals for the four approaches (NS, SN, EW, WE) and keeps a saturating queue count per lane. From those counts it produces the registered demand flags the FSM consumes: `*_S1` (at least one car waiting) and `*_S5` (queue at or above the extension threshold).

---
 rtl/traffic_pkg.sv | 26 ++
 rtl/lane_pulse_filter.sv | 72 +++++++
 rtl/lane_occupancy_counter.sv | 100 ++++++++++
 tb/tb_lane_occupancy_counter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared traffic-controller definitions: lane indices and light-FSM state encodings.
package traffic_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_NS   = 0;
  localparam int unsigned LANE_SN   = 1;
  localparam int unsigned LANE_EW   = 2;
  localparam int unsigned LANE_WE   = 3;

  typedef enum logic [3:0] {
    ST_RESET     = 4'd0,
    ST_NS_GREEN  = 4'd1,
    ST_NS_EXT    = 4'd2,
    ST_NS_YELLOW = 4'd3,
    ST_NS_RED    = 4'd4,
    ST_SN_GREEN  = 4'd5,
    ST_SN_EXT    = 4'd6,
    ST_SN_YELLOW = 4'd7,
    ST_SN_RED    = 4'd8,
    ST_EW_GREEN  = 4'd9,
    ST_EW_EXT    = 4'd10,
    ST_EW_YELLOW = 4'd11,
    ST_WE_GREEN  = 4'd12
  } tl_state_e;

endpackage

// File: rtl/lane_pulse_filter.sv
// Loop-detector conditioning: two-flop synchroniser, optional debounce, rising-edge pulse.
// Debounce is compiled in when LANE_CNT_DEBOUNCE_EN is defined.
module lane_pulse_filter #(
  parameter int unsigned DEB_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic sense,
  output logic pulse_c
);

  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("lane_pulse_filter: DEB_CYCLES must be at least 1");
  end

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic level;

`ifdef LANE_CNT_DEBOUNCE_EN
  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             lvl_q, lvl_d;

  // Filtered level flips only after DEB_CYCLES consecutive disagreeing samples.
  always_comb begin
    deb_cnt_d = '0;
    lvl_d     = lvl_q;
    if (sync2_q != lvl_q) begin
      if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) lvl_d = sync2_q;
      else deb_cnt_d = deb_cnt_q + DEB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_q <= '0;
      lvl_q     <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      lvl_q     <= lvl_d;
    end
  end

  assign level = lvl_q;
`else
  assign level = sync2_q;
`endif

  always_comb begin
    sync1_d = sense;
    sync2_d = sync1_q;
    prev_d  = level;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign pulse_c = level & ~prev_q;

endmodule

// File: rtl/lane_occupancy_counter.sv
// Per-lane saturating queue counters with registered S1/S5 demand flags for the light FSM.
// Optional input debounce via LANE_CNT_DEBOUNCE_EN (see lane_pulse_filter).
module lane_occupancy_counter
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned EXT_THRESH = 5,
  parameter int unsigned DEB_CYCLES = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_LANES-1:0]       arr_sense,
  input  logic [NUM_LANES-1:0]       dep_sense,
  output logic                       NS_S1,
  output logic                       SN_S1,
  output logic                       EW_S1,
  output logic                       WE_S1,
  output logic                       NS_S5,
  output logic                       SN_S5,
  output logic                       EW_S5,
  output logic                       WE_S5,
  output logic [NUM_LANES*CNT_W-1:0] lane_cnt,
  output logic [NUM_LANES-1:0]       sat_err
);

  if (EXT_THRESH < 1 || EXT_THRESH > (2**CNT_W) - 1) begin : g_bad_thresh
    $error("lane_occupancy_counter: EXT_THRESH out of range 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_LANES-1:0] arr_pulse;
  logic [NUM_LANES-1:0] dep_pulse;
  logic [NUM_LANES-1:0] s1_vec;
  logic [NUM_LANES-1:0] s5_vec;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             s1_q, s1_d;
    logic             s5_q, s5_d;

    lane_pulse_filter #(.DEB_CYCLES(DEB_CYCLES)) u_arr (
      .clk    (clk),
      .rst    (rst),
      .sense  (arr_sense[l]),
      .pulse_c(arr_pulse[l])
    );

    lane_pulse_filter #(.DEB_CYCLES(DEB_CYCLES)) u_dep (
      .clk    (clk),
      .rst    (rst),
      .sense  (dep_sense[l]),
      .pulse_c(dep_pulse[l])
    );

    // Simultaneous arrival and departure cancel; underflow is silently ignored.
    always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (arr_pulse[l] && !dep_pulse[l]) begin
        if (cnt_q == CNT_MAX) err_d = 1'b1;
        else cnt_d = cnt_q + CNT_W'(1);
      end else if (dep_pulse[l] && !arr_pulse[l] && cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      s1_d = (cnt_d != '0);
      s5_d = (cnt_d >= CNT_W'(EXT_THRESH));
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
        err_q <= 1'b0;
        s1_q  <= 1'b0;
        s5_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        err_q <= err_d;
        s1_q  <= s1_d;
        s5_q  <= s5_d;
      end
    end

    assign lane_cnt[l*CNT_W +: CNT_W] = cnt_q;
    assign sat_err[l]                 = err_q;
    assign s1_vec[l]                  = s1_q;
    assign s5_vec[l]                  = s5_q;
  end

  assign NS_S1 = s1_vec[LANE_NS];
  assign SN_S1 = s1_vec[LANE_SN];
  assign EW_S1 = s1_vec[LANE_EW];
  assign WE_S1 = s1_vec[LANE_WE];
  assign NS_S5 = s5_vec[LANE_NS];
  assign SN_S5 = s5_vec[LANE_SN];
  assign EW_S5 = s5_vec[LANE_EW];
  assign WE_S5 = s5_vec[LANE_WE];

endmodule

// File: tb/tb_lane_occupancy_counter.sv
// Self-checking bench for lane_occupancy_counter: vector table, corner sequences, random vs. model.
module tb_lane_occupancy_counter;

  localparam int CNT_W = 4;
  localparam int EXT   = 5;
  localparam int DEB   = 3;
`ifdef LANE_CNT_DEBOUNCE_EN
  localparam int LAT    = 3 + DEB;
  localparam bit DEB_ON = 1'b1;
`else
  localparam int LAT    = 3;
  localparam bit DEB_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  arr_sense;
  logic [3:0]  dep_sense;
  logic        NS_S1, SN_S1, EW_S1, WE_S1;
  logic        NS_S5, SN_S5, EW_S5, WE_S5;
  logic [15:0] lane_cnt;
  logic [3:0]  sat_err;

  lane_occupancy_counter #(.CNT_W(CNT_W), .EXT_THRESH(EXT), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .arr_sense(arr_sense), .dep_sense(dep_sense),
    .NS_S1(NS_S1), .SN_S1(SN_S1), .EW_S1(EW_S1), .WE_S1(WE_S1),
    .NS_S5(NS_S5), .SN_S5(SN_S5), .EW_S5(EW_S5), .WE_S5(WE_S5),
    .lane_cnt(lane_cnt), .sat_err(sat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int edge_no  = 0;

  // Reference model state: queue lengths, sticky errors, pending conditioned pulses.
  int mcnt[4];
  bit merr[4];
  bit pinc[4][32];
  bit pdec[4][32];
  logic [3:0] prev_a, prev_d;

  typedef struct {
    logic [3:0]  arr;
    logic [3:0]  dep;
    logic [15:0] cnt;
    logic [3:0]  err;
  } vec_t;
  vec_t tbl[10];

  task automatic tick();
    @(posedge clk);
    #1;
    edge_no++;
  endtask

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (edge %0d): got %h expected %h", name, edge_no, act, exp);
    end
  endtask

  function automatic logic [27:0] obs();
    return {lane_cnt, WE_S1, EW_S1, SN_S1, NS_S1, WE_S5, EW_S5, SN_S5, NS_S5, sat_err};
  endfunction

  function automatic logic [27:0] exp_vec(input logic [15:0] c, input logic [3:0] e);
    logic [3:0] s1, s5, nib;
    for (int l = 0; l < 4; l++) begin
      nib   = c[l*4 +: 4];
      s1[l] = (nib != 4'd0);
      s5[l] = (int'(nib) >= EXT);
    end
    return {c, s1, s5, e};
  endfunction

  function automatic logic [27:0] model_vec();
    logic [15:0] c;
    logic [3:0]  e;
    for (int l = 0; l < 4; l++) begin
      c[l*4 +: 4] = 4'(mcnt[l]);
      e[l]        = merr[l];
    end
    return exp_vec(c, e);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    arr_sense = 4'd0;
    dep_sense = 4'd0;
    tick();
    tick();
    rst = 1'b0;
    prev_a = 4'd0;
    prev_d = 4'd0;
    for (int l = 0; l < 4; l++) begin
      mcnt[l] = 0;
      merr[l] = 1'b0;
      for (int k = 0; k < 32; k++) begin
        pinc[l][k] = 1'b0;
        pdec[l][k] = 1'b0;
      end
    end
  endtask

  task automatic pulse(input logic [3:0] a, input logic [3:0] d);
    arr_sense = a;
    dep_sense = d;
    repeat (4) tick();
    arr_sense = 4'd0;
    dep_sense = 4'd0;
    repeat (4) tick();
  endtask

  // One random-stimulus cycle: schedule raw rises LAT-1 edges out, then apply spec counting rules.
  task automatic model_step();
    int  e;
    bit  inc, dec;
    e = edge_no + 1;
    for (int l = 0; l < 4; l++) begin
      if (arr_sense[l] && !prev_a[l]) pinc[l][(e + LAT - 1) % 32] = 1'b1;
      if (dep_sense[l] && !prev_d[l]) pdec[l][(e + LAT - 1) % 32] = 1'b1;
    end
    prev_a = arr_sense;
    prev_d = dep_sense;
    tick();
    for (int l = 0; l < 4; l++) begin
      inc = pinc[l][edge_no % 32];
      dec = pdec[l][edge_no % 32];
      pinc[l][edge_no % 32] = 1'b0;
      pdec[l][edge_no % 32] = 1'b0;
      if (inc && !dec) begin
        if (mcnt[l] == 15) merr[l] = 1'b1;
        else mcnt[l] = mcnt[l] + 1;
      end else if (dec && !inc && mcnt[l] > 0) begin
        mcnt[l] = mcnt[l] - 1;
      end
    end
    check("random", obs(), model_vec());
  endtask

  int arem[4], drem[4];
  int expn;

  initial begin
    rst = 1'b1;
    arr_sense = 4'd0;
    dep_sense = 4'd0;

    tbl[0] = '{4'b0001, 4'b0000, 16'h0001, 4'h0};
    tbl[1] = '{4'b0000, 4'b0000, 16'h0001, 4'h0};
    tbl[2] = '{4'b1111, 4'b0000, 16'h1112, 4'h0};
    tbl[3] = '{4'b0000, 4'b0000, 16'h1112, 4'h0};
    tbl[4] = '{4'b0000, 4'b0011, 16'h1101, 4'h0};
    tbl[5] = '{4'b0000, 4'b0000, 16'h1101, 4'h0};
    tbl[6] = '{4'b0000, 4'b0010, 16'h1101, 4'h0};
    tbl[7] = '{4'b0000, 4'b0000, 16'h1101, 4'h0};
    tbl[8] = '{4'b1000, 4'b1000, 16'h1101, 4'h0};
    tbl[9] = '{4'b0000, 4'b0000, 16'h1101, 4'h0};

    // Reset with all arrivals held high: counted once, exactly LAT edges after release.
    rst = 1'b1;
    arr_sense = 4'b1111;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 1; k <= LAT + 4; k++) begin
      tick();
      check("reset_release", obs(), exp_vec((k >= LAT) ? 16'h1111 : 16'h0000, 4'h0));
    end

    do_reset();
    check("reset_state", obs(), exp_vec(16'h0000, 4'h0));
    for (int i = 0; i < 10; i++) begin
      arr_sense = tbl[i].arr;
      dep_sense = tbl[i].dep;
      repeat (8) tick();
      check($sformatf("table_%0d", i), obs(), exp_vec(tbl[i].cnt, tbl[i].err));
    end

    // Threshold: five NS pulses, S5 must rise on the same edge as count 5.
    do_reset();
    for (int s = 1; s <= 44; s++) begin
      arr_sense = (((s - 1) % 8) < 4 && s <= 40) ? 4'b0001 : 4'b0000;
      tick();
      expn = 0;
      for (int p = 0; p < 5; p++) if (8 * p + LAT <= s) expn++;
      check("threshold", obs(), exp_vec(16'(expn), 4'h0));
    end

    // Saturation on EW, then a departure leaves the sticky error set.
    do_reset();
    for (int p = 0; p < 16; p++) begin
      pulse(4'b0100, 4'b0000);
      if (p == 14) check("sat_pre", obs(), exp_vec(16'h0F00, 4'h0));
      if (p == 15) check("sat_hit", obs(), exp_vec(16'h0F00, 4'h4));
    end
    pulse(4'b0000, 4'b0100);
    check("sat_dep", obs(), exp_vec(16'h0E00, 4'h4));
    repeat (6) tick();
    check("sat_sticky", obs(), exp_vec(16'h0E00, 4'h4));
    do_reset();
    check("sat_cleared", obs(), exp_vec(16'h0000, 4'h0));

    // WE simultaneous arrival/departure at zero, then lone departure at zero.
    arr_sense = 4'b1000;
    dep_sense = 4'b1000;
    for (int s = 0; s < 8; s++) begin
      if (s == 4) begin arr_sense = 4'd0; dep_sense = 4'd0; end
      tick();
      check("simultaneous", obs(), exp_vec(16'h0000, 4'h0));
    end
    dep_sense = 4'b1000;
    for (int s = 0; s < 10; s++) begin
      if (s == 4) dep_sense = 4'd0;
      tick();
      check("underflow", obs(), exp_vec(16'h0000, 4'h0));
    end

    // SN 2-cycle glitch: suppressed with debounce, counted at edge 3 without.
    do_reset();
    arr_sense = 4'b0010;
    for (int s = 1; s <= 10; s++) begin
      tick();
      if (s == 2) arr_sense = 4'd0;
      check("glitch", obs(), exp_vec((!DEB_ON && s >= 3) ? 16'h0010 : 16'h0000, 4'h0));
    end
    do_reset();
    arr_sense = 4'b0010;
    for (int s = 1; s <= 10; s++) begin
      tick();
      if (s == 3) arr_sense = 4'd0;
      check("pulse3", obs(), exp_vec((s >= LAT) ? 16'h0010 : 16'h0000, 4'h0));
    end

    // Reset while an NS arrival is still in the pipeline.
    do_reset();
    arr_sense = 4'b0001;
    tick();
    tick();
    rst = 1'b1;
    arr_sense = 4'd0;
    tick();
    tick();
    rst = 1'b0;
    for (int s = 0; s < 10; s++) begin
      tick();
      check("midflight", obs(), exp_vec(16'h0000, 4'h0));
    end

    // Random clean pulses: arrival-heavy phase, then departure-heavy phase.
    do_reset();
    for (int l = 0; l < 4; l++) begin
      arem[l] = $urandom_range(1, 4);
      drem[l] = $urandom_range(1, 4);
    end
    for (int c = 0; c < 1200; c++) begin
      for (int l = 0; l < 4; l++) begin
        if (arem[l] == 0) begin
          arr_sense[l] = ~arr_sense[l];
          arem[l] = arr_sense[l] ? $urandom_range(3, 8)
                                 : ((c < 600) ? $urandom_range(3, 6) : $urandom_range(3, 24));
        end
        if (drem[l] == 0) begin
          dep_sense[l] = ~dep_sense[l];
          drem[l] = dep_sense[l] ? $urandom_range(3, 8)
                                 : ((c < 600) ? $urandom_range(3, 24) : $urandom_range(3, 6));
        end
        arem[l]--;
        drem[l]--;
      end
      model_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
